// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-path types and constants for the IF stages
package fetch_pkg;
  localparam int MXLEN = 32;
  localparam int FETCH_BYTES = 8;
  typedef struct packed {
    logic [MXLEN-1:0] pc;
    logic [63:0]      data;
    logic             err;
    logic             filled;
  } fetch_entry_t;
  function automatic logic [MXLEN-1:0] fetch_align(input logic [MXLEN-1:0] pc);
    return pc & ~MXLEN'(FETCH_BYTES - 1);
  endfunction
endpackage

// File: rtl/if1_fetch_queue.sv
// if1_fetch_queue: in-order circular buffer of outstanding and returned fetch packets
module if1_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_alloc,
  input  logic [MXLEN-1:0]  i_alloc_pc,
  input  logic              i_fill,
  input  logic [63:0]       i_fill_data,
  input  logic              i_fill_err,
  input  logic              i_pop,
  output fetch_entry_t      o_head,
  output logic [CW-1:0]     o_used,
  output logic [CW-1:0]     o_pend
);
  fetch_entry_t ent_q [DEPTH];
  logic [PW-1:0] alloc_q, alloc_d, fill_q, fill_d, pop_q, pop_d;
  logic [CW-1:0] used_q, used_d, pend_q, pend_d;
  // pointers wrap naturally since DEPTH is a power of two; pend counts allocated-but-unfilled entries
  always_comb begin
    alloc_d = i_clear ? '0 : alloc_q + PW'(i_alloc);
    fill_d  = i_clear ? '0 : fill_q + PW'(i_fill);
    pop_d   = i_clear ? '0 : pop_q + PW'(i_pop);
    used_d  = i_clear ? '0 : used_q + CW'(i_alloc) - CW'(i_pop);
    pend_d  = i_clear ? '0 : pend_q + CW'(i_alloc) - CW'(i_fill);
  end
  // pointer and occupancy registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      alloc_q <= '0;
      fill_q  <= '0;
      pop_q   <= '0;
      used_q  <= '0;
      pend_q  <= '0;
    end else begin
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      pop_q   <= pop_d;
      used_q  <= used_d;
      pend_q  <= pend_d;
    end
  end
  // entry payload; stale contents are harmless because validity comes from used/filled
  always_ff @(posedge i_clk) begin
    if (i_alloc && !i_clear) ent_q[alloc_q] <= '{pc: i_alloc_pc, data: '0, err: 1'b0, filled: 1'b0};
    if (i_fill && !i_clear) begin
      ent_q[fill_q].data   <= i_fill_data;
      ent_q[fill_q].err    <= i_fill_err;
      ent_q[fill_q].filled <= 1'b1;
    end
  end
  assign o_head = ent_q[pop_q];
  assign o_used = used_q;
  assign o_pend = pend_q;
endmodule

// File: rtl/if1_fetch_ctrl.sv
// if1_fetch_ctrl: issues aligned icache fetches, tracks them in order and hands packets to IF2
module if1_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if0_pc_valid,
  input  logic [MXLEN-1:0]  i_if0_pc,
  output logic              o_if1_stall,
  input  logic              i_flush,
  output logic              o_icache_req_valid,
  output logic [MXLEN-1:0]  o_icache_req_addr,
  input  logic              i_icache_req_ready,
  input  logic              i_icache_rsp_valid,
  input  logic [63:0]       i_icache_rsp_data,
  input  logic              i_icache_rsp_err,
  output logic              o_if2_valid,
  output logic [MXLEN-1:0]  o_if2_pc,
  output logic [63:0]       o_if2_inst,
  output logic [1:0]        o_if2_mask,
  output logic              o_if2_err,
  input  logic              i_if2_ready
);
  fetch_entry_t head;
  logic [CW-1:0] used, pend, drop_q, drop_d;
  logic fire, fill, pop;
  assign o_icache_req_valid = i_if0_pc_valid & ~i_flush & (({1'b0, used} + {1'b0, drop_q}) < (CW + 1)'(DEPTH));
  assign o_icache_req_addr  = fetch_align(i_if0_pc);
  assign fire        = o_icache_req_valid & i_icache_req_ready;
  assign o_if1_stall = i_if0_pc_valid & ~fire;
  assign fill        = i_icache_rsp_valid & (drop_q == '0) & ~i_flush;
  assign o_if2_valid = (used != '0) & head.filled;
  assign pop         = o_if2_valid & i_if2_ready & ~i_flush;
  assign o_if2_pc    = o_if2_valid ? head.pc : '0;
  assign o_if2_inst  = o_if2_valid ? head.data : '0;
  assign o_if2_err   = o_if2_valid & head.err;
  assign o_if2_mask  = o_if2_valid ? (head.pc[2] ? 2'b10 : 2'b11) : 2'b00;
  // on flush every unfilled entry becomes a response to discard, less any response arriving now
  always_comb drop_d = i_flush ? drop_q + pend - CW'(i_icache_rsp_valid)
                               : drop_q - CW'(i_icache_rsp_valid & (drop_q != '0));
  // drop counter register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) drop_q <= '0;
    else drop_q <= drop_d;
  end
  if1_fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (i_flush),
    .i_alloc     (fire),
    .i_alloc_pc  (i_if0_pc),
    .i_fill      (fill),
    .i_fill_data (i_icache_rsp_data),
    .i_fill_err  (i_icache_rsp_err),
    .i_pop       (pop),
    .o_head      (head),
    .o_used      (used),
    .o_pend      (pend)
  );
  rsp_outstanding_a: assert property (@(posedge i_clk) disable iff (i_rst)
    i_icache_rsp_valid |-> (drop_q != '0 || pend != '0))
    else $error("icache response with nothing outstanding");
endmodule

// File: doc/if1_fetch_ctrl.md
# if1_fetch_ctrl

IF1 fetch controller: accepts the current PC from the IF0 PC generator, issues aligned 8-byte fetch requests to the instruction cache, tracks up to DEPTH in-order outstanding requests, and delivers fetch packets (PC, 64-bit data, slot mask, error) to IF2. It sits directly downstream of IF0, back-pressures it through a stall signal, and discards stale responses after a pipeline flush from IF2 or EXU redirects.

## Interface
- DEPTH, 2: maximum outstanding requests plus buffered packets; power of two, ≥2.
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_if0_pc_valid  in  1  IF0 presents a PC to fetch.
- i_if0_pc  in  `MXLEN  PC to fetch.
- o_if1_stall  out  1  IF0 must hold its PC this cycle.
- i_flush  in  1  redirect from IF2/EXU; kills all in-flight work.
- o_icache_req_valid  out  1  request valid.
- o_icache_req_addr  out  `MXLEN  request address, {pc[MXLEN-1:3],3'b000}.
- i_icache_req_ready  in  1  cache accepts request.
- i_icache_rsp_valid  in  1  in-order response; no back-pressure.
- i_icache_rsp_data  in  64  fetch packet.
- i_icache_rsp_err  in  1  access fault.
- o_if2_valid  out  1  packet valid to IF2.
- o_if2_pc  out  `MXLEN  packet PC (unaligned original).
- o_if2_inst  out  64  packet data.
- o_if2_mask  out  2  valid 32-bit slots; 2'b10 if pc[2]=1, else 2'b11.
- o_if2_err  out  1  access fault for packet.
- i_if2_ready  in  1  IF2 consumes packet.

## Operation
- Circular queue of DEPTH entries {pc, data, err, filled}; alloc pointer, fill pointer, pop pointer, count used.
- drop_cnt: responses still owed for flushed requests; width $clog2(DEPTH+1).
- Request: o_icache_req_valid = i_if0_pc_valid & ~i_flush & (used + drop_cnt < DEPTH). Fire = valid & ready allocates entry at alloc pointer with pc, filled=0.
- o_if1_stall = i_if0_pc_valid & ~fire (combinational from i_icache_req_ready).
- Response: if drop_cnt≠0, discard and decrement; else write data/err into entry at fill pointer, set filled, advance fill pointer.
- Output: o_if2_* driven from entry at pop pointer; o_if2_valid = used≠0 & filled. Pop when o_if2_valid & i_if2_ready.
- Flush (highest priority): pop, fill, alloc suppressed; used, all pointers cleared; drop_cnt_next = drop_cnt + (allocated-unfilled entries) − i_icache_rsp_valid. o_if2_valid 0 the following cycle.
- Invariant: used + drop_cnt ≤ DEPTH; total cache outstanding ≤ DEPTH. Response with nothing outstanding is a protocol error (assertion).
- pc[1:0] ignored (no compressed support).

## Timing
- Reset: queue empty, drop_cnt 0; o_if2_valid 0, o_if2_pc/inst/mask/err 0; o_icache_req_valid follows input (0 when i_if0_pc_valid 0).
- Fire in cycle N; earliest response N+1; filled flag registered, so o_if2_valid earliest N+2.
- Alloc, fill, pop same cycle allowed; used updates by +fire −pop.
- Full (used+drop_cnt=DEPTH): no request; stall asserted; pop in same cycle does not free the slot until next cycle.
- Pointers wrap modulo DEPTH.
- Reset mid-operation: all state cleared immediately; responses for pre-reset requests are the cache's responsibility to suppress.

## Structure
- Shared package (bpu_pkg neighbour, fetch_pkg): typedef fetch_entry_t {pc, data, err, filled}; constant FETCH_BYTES=8.
- One sub-module natural: if1_fetch_queue (entries, pointers, used); top holds request gating, drop counter, flush.

## Test plan
- Single fetch: pc 0x1000 valid, ready=1, response 1 cycle later data 0xDEADBEEF_0000_0013 -> o_if2_valid 2 cycles after fire, pc 0x1000, mask 2'b11.
- Unaligned: pc 0x1004 -> req_addr 0x1000, o_if2_mask 2'b10, o_if2_pc 0x1004.
- Back-pressure: DEPTH=2, i_if2_ready=0, cache responds -> two fires, third PC stalls (o_if1_stall=1) until one pop.
- Flush with 2 in flight: flush -> drop_cnt 2; next two responses discarded, o_if2_valid stays 0; new PC 0x2000 delivered afterward.
- Flush coincident with response: 2 outstanding, flush and rsp same cycle -> drop_cnt 1, exactly one later response dropped.
- Async reset mid-stream: i_rst asserted with entries buffered -> o_if2_valid 0 same cycle, queue empty after release.
